// File: rtl/muldiv_if.sv
// Request/response bundle between the EX stage and the multiply-divide unit.
interface muldiv_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [XLEN-1:0]  in_a;
    logic [XLEN-1:0]  in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_result;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    // Pipeline side: issues operations and consumes results.
    modport master (
        output flush, in_valid, in_op, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag, busy
    );

    // Unit side.
    modport slave (
        input  flush, in_valid, in_op, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag, busy
    );
endinterface

// File: rtl/muldiv_unit.sv
// RV32M/RV64M multiply-divide unit: fixed-latency multiply, radix-2 restoring divide.
module muldiv_unit #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned MUL_LATENCY = 2,
    parameter int unsigned TAG_W       = 5
) (
    input  logic     clk,
    input  logic     rst_n,
    muldiv_if.slave  bus
);
    localparam int unsigned CntW = $clog2(XLEN);
    localparam logic [CntW-1:0] MulCnt  = CntW'(MUL_LATENCY > 1 ? MUL_LATENCY - 2 : 0);
    localparam logic [CntW-1:0] DivCnt  = CntW'(XLEN - 1);
    localparam logic [XLEN-1:0] MostNeg = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

    state_e            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [XLEN-1:0]   res_q, res_d;
    logic [2*XLEN-1:0] prod_q, prod_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   quo_q, quo_d;
    logic [XLEN-1:0]   dvs_q, dvs_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              quo_neg_q, quo_neg_d;
    logic              rem_neg_q, rem_neg_d;

    logic              accept;
    logic              a_signed, b_signed, div_signed;
    logic [2*XLEN-1:0] a_ext, b_ext, prod;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN:0]     rem_shift, rem_diff;
    logic [XLEN-1:0]   rem_step, quo_step;

    assign bus.in_ready   = (state_q == StIdle) && !bus.flush;
    assign bus.out_valid  = (state_q == StDone);
    assign bus.busy       = (state_q != StIdle);
    assign bus.out_result = res_q;
    assign bus.out_tag    = tag_q;
    assign accept         = bus.in_valid && bus.in_ready;

    // Operand conditioning, full-width product and one restoring-divide step.
    always_comb begin
        a_signed   = (bus.in_op[1:0] != 2'd3);
        b_signed   = (bus.in_op[1:0] == 2'd0) || (bus.in_op[1:0] == 2'd1);
        a_ext      = {{XLEN{a_signed & bus.in_a[XLEN-1]}}, bus.in_a};
        b_ext      = {{XLEN{b_signed & bus.in_b[XLEN-1]}}, bus.in_b};
        prod       = a_ext * b_ext;
        div_signed = !bus.in_op[0];
        a_mag      = (div_signed && bus.in_a[XLEN-1]) ? -bus.in_a : bus.in_a;
        b_mag      = (div_signed && bus.in_b[XLEN-1]) ? -bus.in_b : bus.in_b;
        rem_shift  = {rem_q, quo_q[XLEN-1]};
        rem_diff   = rem_shift - {1'b0, dvs_q};
        if (!rem_diff[XLEN]) begin
            rem_step = rem_diff[XLEN-1:0];
            quo_step = {quo_q[XLEN-2:0], 1'b1};
        end else begin
            rem_step = rem_shift[XLEN-1:0];
            quo_step = {quo_q[XLEN-2:0], 1'b0};
        end
    end

    // Next-state and datapath register updates.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        tag_d     = tag_q;
        res_d     = res_q;
        prod_d    = prod_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        cnt_d     = cnt_q;
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    op_d  = bus.in_op;
                    tag_d = bus.in_tag;
                    if (!bus.in_op[2]) begin
                        prod_d = prod;
                        if (MUL_LATENCY > 1) begin
                            state_d = StMul;
                            cnt_d   = MulCnt;
                        end else begin
                            state_d = StDone;
                            res_d   = (bus.in_op[1:0] == 2'd0) ? prod[XLEN-1:0]
                                                               : prod[2*XLEN-1:XLEN];
                        end
                    end else if (bus.in_b == '0) begin
                        state_d = StDone;
                        res_d   = bus.in_op[1] ? bus.in_a : '1;
                    end else if (div_signed && bus.in_a == MostNeg && bus.in_b == '1) begin
                        state_d = StDone;
                        res_d   = bus.in_op[1] ? '0 : bus.in_a;
                    end else begin
                        state_d   = StDiv;
                        cnt_d     = DivCnt;
                        rem_d     = '0;
                        quo_d     = a_mag;
                        dvs_d     = b_mag;
                        quo_neg_d = div_signed && (bus.in_a[XLEN-1] ^ bus.in_b[XLEN-1]);
                        rem_neg_d = div_signed && bus.in_a[XLEN-1];
                    end
                end
            end
            StMul: begin
                if (cnt_q == '0) begin
                    state_d = StDone;
                    res_d   = (op_q[1:0] == 2'd0) ? prod_q[XLEN-1:0] : prod_q[2*XLEN-1:XLEN];
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StDiv: begin
                rem_d = rem_step;
                quo_d = quo_step;
                if (cnt_q == '0) begin
                    state_d = StDone;
                    // Sign fix-up: quotient negated on sign mismatch, remainder follows dividend.
                    if (op_q[1]) res_d = rem_neg_q ? -rem_step : rem_step;
                    else         res_d = quo_neg_q ? -quo_step : quo_step;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StDone: begin
                if (bus.out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (bus.flush) state_d = StIdle;
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            op_q      <= '0;
            tag_q     <= '0;
            res_q     <= '0;
            prod_q    <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            tag_q     <= tag_d;
            res_q     <= res_d;
            prod_q    <= prod_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            cnt_q     <= cnt_d;
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit (XLEN 32, MUL_LATENCY 2).
module tb_muldiv_unit;
    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        int          lat;
        int          acc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   pcnt = 0;
    int   checks = 0;
    int   errors = 0;
    bit   force_stall = 0;
    exp_t sb[$];

    muldiv_if #(.XLEN(32), .TAG_W(5)) bus ();

    muldiv_unit #(.XLEN(32), .MUL_LATENCY(2), .TAG_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) pcnt <= pcnt + 1;

    task automatic chk(input bit ok, input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: RISC-V M-extension semantics in plain integer arithmetic.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint          sa, sb, sp;
        longint unsigned up;
        logic [63:0]     w;
        int              ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ia = $signed(a);
        ib = $signed(b);
        case (op)
            3'd0: begin sp = sa * sb; w = sp; return w[31:0]; end
            3'd1: begin sp = sa * sb; w = sp; return w[63:32]; end
            3'd2: begin sp = sa * longint'({32'd0, b}); w = sp; return w[63:32]; end
            3'd3: begin up = {32'd0, a} * {32'd0, b}; w = up; return w[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return ia / ib;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return ia % ib;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int latency(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
        if (op < 4) return 2;
        if (b == 0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Issue one op; expected result either given (use_exp) or from the model.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, input bit use_exp, input logic [31:0] exp,
                         output int acc);
        exp_t e;
        int   n;
        @(negedge clk);
        bus.in_valid = 1;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_tag   = tag;
        n = 0;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        acc = pcnt;
        if (n >= 200) begin
            chk(0, "accept_timeout", 0, 1);
            bus.in_valid = 0;
        end else begin
            e.res = use_exp ? exp : model(op, a, b);
            e.tag = tag;
            e.lat = latency(op, a, b);
            e.acc = pcnt;
            sb.push_back(e);
            @(posedge clk);
            #1;
            bus.in_valid = 0;
            // Scribble inputs: the unit must not re-sample them.
            bus.in_a   = $urandom;
            bus.in_b   = $urandom;
            bus.in_op  = 3'($urandom);
            bus.in_tag = 5'($urandom);
            @(negedge clk);
            chk(bus.busy === 1'b1, "busy_after_accept", 64'(bus.busy), 1);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || bus.busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk(0, "drain_timeout", 64'(sb.size()), 0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom % 5)
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    // Monitor: pops the scoreboard on the first valid cycle, checks every valid cycle.
    initial begin : monitor
        exp_t cur;
        bit   have;
        int   stall;
        have = 0;
        stall = 0;
        bus.out_ready = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                have = 0;
                bus.out_ready = 0;
            end else if (bus.out_valid) begin
                if (!have) begin
                    if (sb.size() == 0) begin
                        chk(0, "unexpected_out_valid", 64'(bus.out_result), 0);
                        bus.out_ready = 1;
                        continue;
                    end
                    cur   = sb.pop_front();
                    have  = 1;
                    stall = force_stall ? 4 : int'($urandom_range(0, 2));
                    chk(pcnt - cur.acc == cur.lat, "latency", 64'(pcnt - cur.acc),
                        64'(cur.lat));
                end
                chk(bus.out_result === cur.res, "result", 64'(bus.out_result), 64'(cur.res));
                chk(bus.out_tag === cur.tag, "tag", 64'(bus.out_tag), 64'(cur.tag));
                chk(bus.in_ready === 1'b0, "in_ready_in_done", 64'(bus.in_ready), 0);
                if (stall > 0) begin
                    stall--;
                    bus.out_ready = 0;
                end else begin
                    bus.out_ready = 1;
                    have = 0;
                end
            end else begin
                if (have) chk(0, "out_valid_dropped", 0, 1);
                have = 0;
                bus.out_ready = 1'($urandom);
            end
        end
    end

    initial begin : driver
        int acc;
        logic [2:0] op;
        bus.flush    = 0;
        bus.in_valid = 0;
        bus.in_op    = 0;
        bus.in_a     = 0;
        bus.in_b     = 0;
        bus.in_tag   = 0;
        rst_n = 0;
        #12;
        chk(bus.out_valid === 1'b0, "rst_out_valid", 64'(bus.out_valid), 0);
        chk(bus.out_result === 32'd0, "rst_out_result", 64'(bus.out_result), 0);
        chk(bus.out_tag === 5'd0, "rst_out_tag", 64'(bus.out_tag), 0);
        chk(bus.busy === 1'b0, "rst_busy", 64'(bus.busy), 0);
        chk(bus.in_ready === 1'b1, "rst_in_ready", 64'(bus.in_ready), 1);
        @(negedge clk);
        rst_n = 1;

        // Directed vectors with hand-derived results.
        issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 1, 32'hFFFF_FFEB, acc);
        issue(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1, 1, 32'h4000_0000, acc);
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 1, 32'hFFFF_FFFE, acc);
        issue(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd3, 1, 32'hFFFF_FFFF, acc);
        issue(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, 1, 32'hFFFF_FFFD, acc);
        issue(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 1, 32'hFFFF_FFFF, acc);
        issue(3'd5, 32'd100, 32'd7, 5'd7, 1, 32'd14, acc);
        issue(3'd7, 32'd100, 32'd7, 5'd8, 1, 32'd2, acc);
        issue(3'd5, 32'd5, 32'd0, 5'd9, 1, 32'hFFFF_FFFF, acc);
        issue(3'd6, 32'd5, 32'd0, 5'd10, 1, 32'd5, acc);
        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 1, 32'h8000_0000, acc);
        issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 1, 32'd0, acc);
        drain();

        // Backpressure: consumer holds off four cycles in DONE.
        force_stall = 1;
        issue(3'd4, 32'd1000, 32'hFFFF_FFFD, 5'd13, 0, 0, acc);
        issue(3'd1, 32'h1234_5678, 32'h8765_4321, 5'd14, 0, 0, acc);
        drain();
        force_stall = 0;

        // Flush at edge 10 of a divide.
        issue(3'd4, 32'd1000, 32'd3, 5'd15, 0, 0, acc);
        while (pcnt < acc + 10) @(negedge clk);
        bus.flush = 1;
        #1;
        chk(bus.in_ready === 1'b0, "flush_in_ready", 64'(bus.in_ready), 0);
        sb.delete();
        @(negedge clk);
        bus.flush = 0;
        chk(bus.busy === 1'b0, "flush_busy", 64'(bus.busy), 0);
        chk(bus.out_valid === 1'b0, "flush_out_valid", 64'(bus.out_valid), 0);
        repeat (40) @(negedge clk);
        issue(3'd7, 32'd1000, 32'd3, 5'd16, 1, 32'd1, acc);
        drain();

        // Randomised traffic against the reference model.
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom);
            issue(op, pick(), pick(), 5'($urandom), 0, 0, acc);
        end
        drain();

        // Asynchronous reset mid-divide.
        issue(3'd5, 32'hDEAD_BEEF, 32'd17, 5'd21, 0, 0, acc);
        repeat (5) @(negedge clk);
        #2;
        rst_n = 0;
        #1;
        sb.delete();
        chk(bus.out_valid === 1'b0, "rst2_out_valid", 64'(bus.out_valid), 0);
        chk(bus.out_result === 32'd0, "rst2_out_result", 64'(bus.out_result), 0);
        chk(bus.out_tag === 5'd0, "rst2_out_tag", 64'(bus.out_tag), 0);
        chk(bus.busy === 1'b0, "rst2_busy", 64'(bus.busy), 0);
        @(negedge clk);
        rst_n = 1;
        repeat (40) @(negedge clk);
        issue(3'd0, 32'd3, 32'd4, 5'd22, 1, 32'd12, acc);
        drain();

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised RV32M/RV64M multiply-divide execution unit attached beside the ALU in the EX stage of the five-stage pipeline. It accepts one operation at a time over a valid/ready handshake, returns a tagged result over a second valid/ready handshake, and stalls the pipeline through `busy` while an operation is in flight. Multiply has a fixed configurable latency; divide and remainder use a radix-2 iterative restoring algorithm with single-cycle special cases.

## Interface
- `XLEN`, 32 — operand and result width (32 or 64).
- `MUL_LATENCY`, 2 — cycles from accept to `out_valid` for MUL*; legal 1..4.
- `TAG_W`, 5 — width of the destination-register tag carried with the operation.

- `clk`  in  1  rising-edge clock; the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous kill of any in-flight or completed operation.
- `in_valid`  in  1  operation request.
- `in_ready`  out  1  unit can accept; `(state == IDLE) && !flush`.
- `in_op`  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `in_a`  in  XLEN  rs1 operand.
- `in_b`  in  XLEN  rs2 operand.
- `in_tag`  in  TAG_W  rd address.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes result.
- `out_result`  out  XLEN  result.
- `out_tag`  out  TAG_W  tag captured at accept.
- `busy`  out  1  `state != IDLE`.

## Operation
- FSM states: IDLE, MUL, DIV, DONE.
- Accept = `in_valid && in_ready`; latches op, operands, and tag.
- IDLE → MUL for op 0–3 when `MUL_LATENCY > 1`. Otherwise → DONE directly.
- IDLE → DONE for divide special cases:
  - Divisor zero: quotient all ones; remainder = `in_a`.
  - Signed overflow (`in_a` = most-negative, `in_b` = −1, DIV/REM): quotient = `in_a`; remainder 0.
- IDLE → DIV for all other op 4–7.
- MUL: down-counter loaded with `MUL_LATENCY−2`; → DONE when it reaches 0.
  - Full 2·XLEN product, operands sign/zero-extended per op.
  - MUL returns the low XLEN bits; the others return the high XLEN bits.
- DIV: signed ops divide magnitudes.
  - One quotient bit per cycle for XLEN cycles; counter counts XLEN−1..0.
  - → DONE at 0; sign fix-up applied on that transition.
  - Quotient negated if operand signs differ; remainder takes the dividend's sign.
  - Truncating division per RISC-V.
- DONE: `out_valid` = 1; result and tag held stable until `out_ready`. Handshake → IDLE.
- `flush` (priority over all): → IDLE next edge. Result discarded, `out_valid` low next cycle, `in_ready` forced low during the flush cycle.
- Internal: 2·XLEN-bit product register, XLEN remainder / quotient / divisor registers, `$clog2(XLEN)`-bit counter.

## Timing
- Reset (async, `rst_n` low): state IDLE, `out_valid` 0, `out_result` 0, `out_tag` 0, `busy` 0.
  - `in_ready` 1 while `flush` is low.
  - Reset mid-operation aborts immediately; no output is produced.
- Accept at edge 0. `out_valid` rises after:
  - MUL*: edge `MUL_LATENCY`.
  - Divide special cases: edge 1.
  - Normal divide: edge XLEN+1.
- `busy` rises the cycle after accept and falls the cycle after the output handshake.
- Back-to-back: `in_ready` low in DONE. The earliest next accept is the cycle after the output handshake, so throughput is at most one op per (latency + 1) cycles.
- `out_valid` never drops without `out_ready` except on `flush` or reset.
- Operands are not re-sampled after accept; input changes while busy have no effect.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3), `MUL_LATENCY` = 2, tag 5 → `out_valid` at edge 2, result 0xFFFFFFEB, tag 5.
- Upper-half multiplies (XLEN 32):
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- Signed divide, each `out_valid` at edge 33:
  - DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD.
  - REM −7 % 2 → 0xFFFFFFFF.
  - DIVU 100 / 7 → 14.
  - REMU 100 % 7 → 2.
- Divide special cases, each `out_valid` at edge 1:
  - DIVU 5 / 0 → 0xFFFFFFFF.
  - REM 5 % 0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM of the same operands → 0.
- Backpressure and flush:
  - `out_ready` low 4 cycles in DONE → result and tag stable, `in_ready` 0.
  - `flush` pulsed at edge 10 of a DIV → `busy` 0 at edge 11, no `out_valid`, new op accepted.
- Reset: `rst_n` low for 1 cycle mid-DIV → outputs at reset values immediately. A subsequent MUL 3 × 4 returns 12.
